// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the CPU pipeline and the memory arbiter.
//   ADDR_W_DEF / DATA_W_DEF : default SRAM address and data widths
//   NOP_INSTR               : instruction the fetch stage uses while the bus is taken
//   arb_state_t             : memory arbiter FSM states (3-bit encoding)
package cpu_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_RD        = 3'd2,
    ST_WR_SETUP  = 3'd3,
    ST_WR_STROBE = 3'd4,
    ST_WR_HOLD   = 3'd5
  } arb_state_t;

  // True while a load or store owns the SRAM bus.
  function automatic logic is_data_state(arb_state_t s);
    return (s == ST_RD) || (s == ST_WR_SETUP) || (s == ST_WR_STROBE) ||
           (s == ST_WR_HOLD);
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one asynchronous SRAM port between instruction fetch and
// the MEM stage (loads/stores), sequencing the SRAM strobes.
// Ports:
//   clk, rst                  clock, async active-high reset
//   if_req/if_addr            fetch request and PC
//   if_data/if_valid          fetched word (NOP when not fetching), fetch strobe
//   mem_rd/mem_wr             load/store requests, held until mem_done
//   mem_addr/mem_wdata        load/store address and store data
//   mem_rdata/mem_done        load data (valid in RD), access-complete strobe
//   mem_conflict              fetch stage must substitute a NOP
//   sram_addr/sram_wdata      latched access address and store data
//   sram_rdata                SRAM bus read data
//   sram_drive                tri-state enable for sram_wdata
//   sram_ce_n/oe_n/we_n       active-low SRAM controls
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_data,
  output logic              if_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              mem_conflict,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              sram_drive,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  // Leaving a data access only considers fetch, so every load/store is
  // followed by a fetch slot and the retiring request is not relaunched.
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE, ST_FETCH: begin
        if (mem_wr)      w_next = ST_WR_SETUP;
        else if (mem_rd) w_next = ST_RD;
        else if (if_req) w_next = ST_FETCH;
        else             w_next = ST_IDLE;
      end
      ST_RD, ST_WR_HOLD: w_next = if_req ? ST_FETCH : ST_IDLE;
      ST_WR_SETUP:       w_next = ST_WR_STROBE;
      ST_WR_STROBE:      w_next = ST_WR_HOLD;
      default:           w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_FETCH) begin
        r_addr <= if_addr;
      end else if ((w_next == ST_RD || w_next == ST_WR_SETUP) &&
                   !is_data_state(r_state)) begin
        r_addr  <= mem_addr;
        r_wdata <= mem_wdata;
      end
    end
  end

  // Moore decode: strobes follow the state register only, so an async reset
  // releases them immediately.
  always_comb begin
    sram_ce_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_drive = 1'b0;
    if_valid   = 1'b0;
    mem_done   = 1'b0;
    if_data    = DATA_W'(NOP_INSTR);
    mem_rdata  = '0;
    case (r_state)
      ST_FETCH: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        if_valid  = 1'b1;
        if_data   = sram_rdata;
      end
      ST_RD: begin
        sram_ce_n = 1'b0;
        sram_oe_n = 1'b0;
        mem_done  = 1'b1;
        mem_rdata = sram_rdata;
      end
      ST_WR_SETUP: begin
        sram_ce_n  = 1'b0;
        sram_drive = 1'b1;
      end
      ST_WR_STROBE: begin
        sram_ce_n  = 1'b0;
        sram_drive = 1'b1;
        sram_we_n  = 1'b0;
      end
      ST_WR_HOLD: begin
        sram_ce_n  = 1'b0;
        sram_drive = 1'b1;
        mem_done   = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_conflict = mem_rd | mem_wr | is_data_state(r_state);
  assign sram_addr    = r_addr;
  assign sram_wdata   = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_data;
  logic        if_valid;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_done, mem_conflict;
  logic [15:0] sram_addr, sram_wdata, sram_rdata;
  logic        sram_drive, sram_ce_n, sram_oe_n, sram_we_n;

  int total = 0;
  int bad   = 0;

  // Output signature {ce_n, oe_n, we_n, drive, if_valid, mem_done} per state.
  localparam logic [5:0] S_IDLE  = 6'b111000;
  localparam logic [5:0] S_FETCH = 6'b001010;
  localparam logic [5:0] S_RD    = 6'b001001;
  localparam logic [5:0] S_WSET  = 6'b011100;
  localparam logic [5:0] S_WSTB  = 6'b010100;
  localparam logic [5:0] S_WHLD  = 6'b011101;

  logic [5:0] sig;
  assign sig = {sram_ce_n, sram_oe_n, sram_we_n, sram_drive, if_valid, mem_done};

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_valid(if_valid),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_conflict(mem_conflict),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_drive(sram_drive), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n)
  );

  // Inputs change and outputs are checked at the falling edge.
  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_addr = '0; mem_rd = 0; mem_wr = 0;
    mem_addr = '0; mem_wdata = '0; sram_rdata = 16'h1111;
    repeat (2) @(negedge clk);
    total++; if (sig !== S_IDLE) begin bad++; $display("FAIL reset_sig got=%b exp=%b", sig, S_IDLE); end
    total++; if (sram_addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got=%h exp=0000", sram_addr); end
    total++; if (sram_wdata !== 16'h0000) begin bad++; $display("FAIL reset_wdata got=%h exp=0000", sram_wdata); end
    total++; if (if_data !== 16'h0800) begin bad++; $display("FAIL reset_if_data got=%h exp=0800", if_data); end
    total++; if (mem_rdata !== 16'h0000) begin bad++; $display("FAIL reset_mem_rdata got=%h exp=0000", mem_rdata); end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 16'h0004; sram_rdata = 16'h69BF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (sig !== S_FETCH) begin bad++; $display("FAIL fetch_sig[%0d] got=%b exp=%b", i, sig, S_FETCH); end
      total++; if (if_data !== 16'h69BF) begin bad++; $display("FAIL fetch_data[%0d] got=%h exp=69BF", i, if_data); end
      total++; if (sram_addr !== 16'h0004) begin bad++; $display("FAIL fetch_addr[%0d] got=%h exp=0004", i, sram_addr); end
      total++; if (mem_conflict !== 1'b0) begin bad++; $display("FAIL fetch_conflict[%0d] got=%b exp=0", i, mem_conflict); end
    end
  endtask

  // Entered while the DUT is in FETCH at a falling edge.
  task automatic test_store_mid_fetch();
    mem_wr = 1; mem_addr = 16'hBF00; mem_wdata = 16'h00CF;
    #1;
    total++; if (mem_conflict !== 1'b1) begin bad++; $display("FAIL st_conflict got=%b exp=1", mem_conflict); end
    @(negedge clk);
    total++; if (sig !== S_WSET) begin bad++; $display("FAIL st_setup got=%b exp=%b", sig, S_WSET); end
    total++; if (sram_addr !== 16'hBF00) begin bad++; $display("FAIL st_addr got=%h exp=BF00", sram_addr); end
    total++; if (sram_wdata !== 16'h00CF) begin bad++; $display("FAIL st_wdata got=%h exp=00CF", sram_wdata); end
    total++; if (if_data !== 16'h0800) begin bad++; $display("FAIL st_nop got=%h exp=0800", if_data); end
    mem_addr = 16'h1234; mem_wdata = 16'hFFFF; // must be ignored mid-access
    @(negedge clk);
    total++; if (sig !== S_WSTB) begin bad++; $display("FAIL st_strobe got=%b exp=%b", sig, S_WSTB); end
    total++; if (sram_addr !== 16'hBF00) begin bad++; $display("FAIL st_addr_hold got=%h exp=BF00", sram_addr); end
    total++; if (sram_wdata !== 16'h00CF) begin bad++; $display("FAIL st_wdata_hold got=%h exp=00CF", sram_wdata); end
    @(negedge clk);
    total++; if (sig !== S_WHLD) begin bad++; $display("FAIL st_hold got=%b exp=%b", sig, S_WHLD); end
    total++; if (mem_conflict !== 1'b1) begin bad++; $display("FAIL st_conflict_hold got=%b exp=1", mem_conflict); end
    @(negedge clk); // mem_wr still high across the HOLD edge: fairness picks FETCH
    total++; if (sig !== S_FETCH) begin bad++; $display("FAIL st_after got=%b exp=%b", sig, S_FETCH); end
    total++; if (sram_addr !== 16'h0004) begin bad++; $display("FAIL st_after_addr got=%h exp=0004", sram_addr); end
    mem_wr = 0;
  endtask

  // Entered while in FETCH with if_req=1, if_addr=0004.
  task automatic test_back_to_back();
    mem_rd = 1; mem_addr = 16'h0008; sram_rdata = 16'hA5A5;
    @(negedge clk);
    total++; if (sig !== S_RD) begin bad++; $display("FAIL ld1_sig got=%b exp=%b", sig, S_RD); end
    total++; if (mem_rdata !== 16'hA5A5) begin bad++; $display("FAIL ld1_data got=%h exp=A5A5", mem_rdata); end
    total++; if (sram_addr !== 16'h0008) begin bad++; $display("FAIL ld1_addr got=%h exp=0008", sram_addr); end
    mem_addr = 16'h0010; sram_rdata = 16'h5A5A; // second load, mem_rd stays high
    @(negedge clk);
    total++; if (sig !== S_FETCH) begin bad++; $display("FAIL ld_slot got=%b exp=%b", sig, S_FETCH); end
    total++; if (if_data !== 16'h5A5A) begin bad++; $display("FAIL ld_slot_data got=%h exp=5A5A", if_data); end
    total++; if (mem_rdata !== 16'h0000) begin bad++; $display("FAIL ld_slot_rdata got=%h exp=0000", mem_rdata); end
    sram_rdata = 16'h1357;
    @(negedge clk);
    total++; if (sig !== S_RD) begin bad++; $display("FAIL ld2_sig got=%b exp=%b", sig, S_RD); end
    total++; if (mem_rdata !== 16'h1357) begin bad++; $display("FAIL ld2_data got=%h exp=1357", mem_rdata); end
    total++; if (sram_addr !== 16'h0010) begin bad++; $display("FAIL ld2_addr got=%h exp=0010", sram_addr); end
    mem_rd = 0; if_req = 0;
    @(negedge clk);
    total++; if (sig !== S_IDLE) begin bad++; $display("FAIL ld_end got=%b exp=%b", sig, S_IDLE); end
  endtask

  // Entered in IDLE.
  task automatic test_simultaneous();
    mem_rd = 1; mem_wr = 1; mem_addr = 16'h0020; mem_wdata = 16'hBEEF; sram_rdata = 16'h2468;
    @(negedge clk);
    total++; if (sig !== S_WSET) begin bad++; $display("FAIL sim_setup got=%b exp=%b", sig, S_WSET); end
    total++; if (sram_wdata !== 16'hBEEF) begin bad++; $display("FAIL sim_wdata got=%h exp=BEEF", sram_wdata); end
    @(negedge clk);
    total++; if (sig !== S_WSTB) begin bad++; $display("FAIL sim_strobe got=%b exp=%b", sig, S_WSTB); end
    @(negedge clk);
    total++; if (sig !== S_WHLD) begin bad++; $display("FAIL sim_hold got=%b exp=%b", sig, S_WHLD); end
    @(negedge clk);
    total++; if (sig !== S_IDLE) begin bad++; $display("FAIL sim_gap got=%b exp=%b", sig, S_IDLE); end
    mem_wr = 0;
    @(negedge clk);
    total++; if (sig !== S_RD) begin bad++; $display("FAIL sim_rd got=%b exp=%b", sig, S_RD); end
    total++; if (mem_rdata !== 16'h2468) begin bad++; $display("FAIL sim_rdata got=%h exp=2468", mem_rdata); end
    total++; if (sram_addr !== 16'h0020) begin bad++; $display("FAIL sim_addr got=%h exp=0020", sram_addr); end
    mem_rd = 0;
    @(negedge clk);
  endtask

  // Entered in IDLE.
  task automatic test_reset_mid_write();
    mem_wr = 1; mem_addr = 16'h0030; mem_wdata = 16'h7777;
    @(negedge clk);
    @(negedge clk);
    total++; if (sig !== S_WSTB) begin bad++; $display("FAIL rmw_strobe got=%b exp=%b", sig, S_WSTB); end
    #1 rst = 1'b1;
    #1;
    total++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL rmw_we_n got=%b exp=1", sram_we_n); end
    total++; if (sram_drive !== 1'b0) begin bad++; $display("FAIL rmw_drive got=%b exp=0", sram_drive); end
    total++; if (sram_ce_n !== 1'b1) begin bad++; $display("FAIL rmw_ce_n got=%b exp=1", sram_ce_n); end
    total++; if (sram_addr !== 16'h0000) begin bad++; $display("FAIL rmw_addr got=%h exp=0000", sram_addr); end
    mem_wr = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++; if (sig !== S_IDLE) begin bad++; $display("FAIL rmw_idle got=%b exp=%b", sig, S_IDLE); end
  endtask

  task automatic test_idle();
    if_req = 0; mem_rd = 0; mem_wr = 0; sram_rdata = 16'hDEAD;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if (sig !== S_IDLE) begin bad++; $display("FAIL idle_sig[%0d] got=%b exp=%b", i, sig, S_IDLE); end
      total++; if (if_data !== 16'h0800) begin bad++; $display("FAIL idle_nop[%0d] got=%h exp=0800", i, if_data); end
      total++; if (mem_conflict !== 1'b0) begin bad++; $display("FAIL idle_conflict[%0d] got=%b exp=0", i, mem_conflict); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_mid_fetch();
    test_back_to_back();
    test_simultaneous();
    test_reset_mid_write();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external SRAM port between the instruction-fetch stage and the MEM stage (load/store).
- Sequences SRAM read and write strobes and latches the access address at grant.
- Raises mem_conflict so the fetch stage substitutes a NOP (16'h0800) while a data access owns the bus.
- Sits between the CPU pipeline (IF and MEM stages) and the board SRAM pins.

Parameters:
- ADDR_W, 16, width of the SRAM address and of both requester addresses.
- DATA_W, 16, width of the SRAM data word.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level; sampled only during arbitration.
- if_addr  in  ADDR_W  fetch address (PC).
- if_data  out  DATA_W  fetched word; equals sram_rdata during FETCH, else 16'h0800.
- if_valid  out  1  high for exactly the FETCH cycle.
- mem_rd  in  1  load request, level, held until mem_done.
- mem_wr  in  1  store request, level, held until mem_done.
- mem_addr  in  ADDR_W  load/store address.
- mem_wdata  in  DATA_W  store data.
- mem_rdata  out  DATA_W  equals sram_rdata during RD, else 0.
- mem_done  out  1  high in the final cycle of a data access (RD or WR_HOLD).
- mem_conflict  out  1  combinational: mem_rd | mem_wr | (state in RD, WR_SETUP, WR_STROBE, WR_HOLD).
- sram_addr  out  ADDR_W  latched access address.
- sram_wdata  out  DATA_W  latched store data.
- sram_rdata  in  DATA_W  data from the SRAM bus.
- sram_drive  out  1  tri-state enable for sram_wdata onto the bus.
- sram_ce_n  out  1  chip enable, active-low.
- sram_oe_n  out  1  output enable, active-low.
- sram_we_n  out  1  write enable, active-low.

Behaviour:
- Reset (async, immediate): state = IDLE; sram_ce_n, sram_oe_n and sram_we_n = 1; sram_drive = 0; sram_addr and sram_wdata = 0; if_valid and mem_done = 0.
- Reset during WR_STROBE releases sram_we_n at once, with no wait for a clock edge.
- States: IDLE, FETCH, RD, WR_SETUP, WR_STROBE, WR_HOLD. All strobes are Moore outputs decoded from the state register.
- Arbitration, evaluated in IDLE, FETCH and WR_HOLD/RD (the final states), priority order:
  - mem_wr -> WR_SETUP
  - mem_rd -> RD
  - if_req -> FETCH
  - otherwise IDLE
- Fairness rule: arbitration out of RD or WR_HOLD ignores mem_rd and mem_wr, so the next state is FETCH (if if_req) or IDLE. This guarantees one fetch slot after every data access and prevents relaunching the request being retired.
- Address/data latching: on entry to FETCH, sram_addr <= if_addr. On entry to RD or WR_SETUP, sram_addr <= mem_addr and sram_wdata <= mem_wdata.
- FETCH, 1 cycle: ce_n = 0, oe_n = 0; if_valid = 1; if_data = sram_rdata.
- RD, 1 cycle: ce_n = 0, oe_n = 0; mem_done = 1; mem_rdata = sram_rdata. The requester samples at the rising edge ending RD and drops mem_rd.
- WR_SETUP: ce_n = 0, drive = 1, we_n = 1.
- WR_STROBE: ce_n = 0, drive = 1, we_n = 0.
- WR_HOLD: ce_n = 0, drive = 1, we_n = 1, mem_done = 1.
- During any write state oe_n = 1.
- Latency from the request visible in IDLE: load 2 cycles to mem_done; store 4 cycles to mem_done; fetch 2 cycles to if_valid.
- mem_rd and mem_wr both high: store wins. The load is served at the next data grant if still asserted.
- Data requests arriving mid-FETCH are taken at the end of FETCH. mem_conflict goes high in the same cycle the request appears.
- Requests change during an access: the latched address and data are used, and input changes are ignored.
- No address wrap or arithmetic: addresses pass through unmodified.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum (6 states, 3-bit encoding);
  - the NOP_INSTR constant = 16'h0800, shared with the fetch stage;
  - ADDR_W and DATA_W defaults.
- No sub-module: a single FSM plus latch registers.

Test Plan:
- Fetch only: rst pulse, if_req = 1 held, if_addr = 16'h0004, sram_rdata = 16'h69BF -> FETCH every cycle; if_valid = 1 and if_data = 16'h69BF; sram_oe_n = 0, sram_we_n = 1 throughout.
- Store mid-fetch: mem_wr = 1, mem_addr = 16'hBF00, mem_wdata = 16'h00CF -> mem_conflict = 1 the same cycle; WR_SETUP/STROBE/HOLD with sram_addr = BF00 and sram_wdata = 00CF; sram_we_n low exactly 1 cycle; mem_done in HOLD; next state FETCH.
- Back-to-back loads: mem_rd held over two requests at 16'h0008 and 16'h0010 -> RD, FETCH, RD ordering (fairness slot); mem_rdata equals the bus value in each RD cycle.
- Simultaneous mem_rd = 1 and mem_wr = 1 from IDLE -> WR_SETUP first; RD granted after the intervening FETCH/IDLE cycle.
- Reset mid-write: assert rst during WR_STROBE -> sram_we_n = 1, sram_drive = 0 and sram_ce_n = 1 before the next clk edge; state IDLE after rst falls.
- Idle: all requests 0 for 10 cycles -> IDLE; ce_n, oe_n and we_n = 1; if_data = 16'h0800; mem_conflict = 0.
